// File: rtl/alu_lockstep_checker.sv
// -----------------------------------------------------------------------------
// alu_lockstep_checker
//
// Dual-channel ALU with a two-stage registered pipeline and an output
// comparator for fault detection. In independent mode each channel has its
// own operands and opcode; in lockstep mode channel 1 reuses channel 0's
// operands and opcode so that any difference between the two results
// indicates a fault in one of the datapaths. Mismatches drive a saturating
// error counter, a three-state health FSM (OK / DEGRADED / FAULT), a sticky
// fault flag and a one-cycle interrupt pulse on entry to FAULT.
//
// Ports
//   wb_clk_i      clock, all logic on the rising edge
//   wb_rst_ni     synchronous reset, active-low
//   in_valid_i    operands/selects valid this cycle
//   mode_i        0 = independent, 1 = lockstep
//   a0_i, b0_i    channel-0 operands
//   a1_i, b1_i    channel-1 operands (ignored in lockstep)
//   sel0_i/sel1_i opcodes
//   clr_i         clear counter, FSM and interrupt
//   out_valid_o   results valid (in_valid_i delayed by 2)
//   alu_out*_o    channel results
//   carry*_o      channel carry/borrow
//   diff_o        alu_out0_o ^ alu_out1_o
//   carry_diff_o  carry0_o ^ carry1_o
//   mismatch_o    valid result pair that differs
//   err_cnt_o     saturating mismatch count
//   state_o       00 = OK, 01 = DEGRADED, 10 = FAULT
//   fault_o       sticky fault flag
//   irq_o         one-cycle pulse on entry to FAULT
// -----------------------------------------------------------------------------
module alu_lockstep_checker #(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             in_valid_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [2:0]       sel0_i,
  input  logic [2:0]       sel1_i,
  input  logic             clr_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] alu_out0_o,
  output logic [WIDTH-1:0] alu_out1_o,
  output logic             carry0_o,
  output logic             carry1_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             carry_diff_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [1:0]       state_o,
  output logic             fault_o,
  output logic             irq_o
);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_DEGRADED = 2'b01;
  localparam logic [1:0] ST_FAULT    = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

  // Returns {carry, result}.
  function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0]       sel);
    logic [WIDTH:0] res;
    res = '0;
    case (sel)
      3'b000:  res = {1'b0, a} + {1'b0, b};
      3'b001:  res = {(a < b), a - b};
      3'b010:  res = {1'b0, a & b};
      3'b011:  res = {1'b0, a | b};
      3'b100:  res = {1'b0, a ^ b};
      3'b101:  res = {1'b0, ~a};
      3'b110:  res = {a, 1'b0};          // carry is the bit shifted out
      default: res = {1'b0, b};
    endcase
    return res;
  endfunction

  // Stage 1: captured operands
  logic             r_s1_valid;
  logic             r_mode;
  logic [WIDTH-1:0] r_a0, r_b0, r_a1, r_b1;
  logic [2:0]       r_sel0, r_sel1;

  // Stage 2: registered results
  logic             r_valid;
  logic [WIDTH-1:0] r_out0, r_out1;
  logic             r_c0, r_c1;

  // Health monitor
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_state;
  logic             r_irq;

  logic [WIDTH-1:0] w_a1, w_b1;
  logic [2:0]       w_sel1;
  logic [WIDTH:0]   w_alu0, w_alu1;
  logic [WIDTH-1:0] w_diff;
  logic             w_carry_diff;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_state_nxt;

  // Lockstep is resolved from the captured mode so in-flight ops keep theirs.
  assign w_a1   = r_mode ? r_a0   : r_a1;
  assign w_b1   = r_mode ? r_b0   : r_b1;
  assign w_sel1 = r_mode ? r_sel0 : r_sel1;
  assign w_alu0 = alu_op(r_a0, r_b0, r_sel0);
  assign w_alu1 = alu_op(w_a1, w_b1, w_sel1);

  assign w_diff       = r_out0 ^ r_out1;
  assign w_carry_diff = r_c0 ^ r_c1;
  assign w_mismatch   = r_valid & ((|w_diff) | w_carry_diff);

  assign w_cnt_nxt = (w_mismatch && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;

  // From OK the next count is at most 1, so OK -> FAULT only fires when the
  // threshold is 1.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // w_state_nxt unassigned, which would infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_OK: begin
        if (w_cnt_nxt >= THRESH)     w_state_nxt = ST_FAULT;
        else if (w_cnt_nxt != '0)    w_state_nxt = ST_DEGRADED;
      end
      ST_DEGRADED: begin
        if (w_cnt_nxt >= THRESH)     w_state_nxt = ST_FAULT;
      end
      ST_FAULT:                      w_state_nxt = ST_FAULT;
      default:                       w_state_nxt = ST_OK;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: the operand and result registers are reset too, so every output
    // reads 0 after reset and in-flight ops are dropped.
    if (!wb_rst_ni) begin
      r_s1_valid <= 1'b0;
      r_mode     <= 1'b0;
      r_a0       <= '0;
      r_b0       <= '0;
      r_a1       <= '0;
      r_b1       <= '0;
      r_sel0     <= '0;
      r_sel1     <= '0;
      r_valid    <= 1'b0;
      r_out0     <= '0;
      r_out1     <= '0;
      r_c0       <= 1'b0;
      r_c1       <= 1'b0;
      r_cnt      <= '0;
      r_state    <= ST_OK;
      r_irq      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_mode <= mode_i;
        r_a0   <= a0_i;
        r_b0   <= b0_i;
        r_a1   <= a1_i;
        r_b1   <= b1_i;
        r_sel0 <= sel0_i;
        r_sel1 <= sel1_i;
      end

      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out0 <= w_alu0[WIDTH-1:0];
        r_c0   <= w_alu0[WIDTH];
        r_out1 <= w_alu1[WIDTH-1:0];
        r_c1   <= w_alu1[WIDTH];
      end

      // Clear wins over a mismatch in the same cycle.
      if (clr_i) begin
        r_cnt   <= '0;
        r_state <= ST_OK;
        r_irq   <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_state <= w_state_nxt;
        r_irq   <= (w_state_nxt == ST_FAULT) && (r_state != ST_FAULT);
      end
    end
  end

  assign out_valid_o  = r_valid;
  assign alu_out0_o   = r_out0;
  assign alu_out1_o   = r_out1;
  assign carry0_o     = r_c0;
  assign carry1_o     = r_c1;
  assign diff_o       = w_diff;
  assign carry_diff_o = w_carry_diff;
  assign mismatch_o   = w_mismatch;
  assign err_cnt_o    = r_cnt;
  assign state_o      = r_state;
  assign fault_o      = (r_state == ST_FAULT);
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// -----------------------------------------------------------------------------
// tb_alu_lockstep_checker
//
// Drives two instances with identical stimulus: the default configuration
// (WIDTH=4, CNT_W=8, FAULT_THRESH=4) and a small-counter one (CNT_W=3,
// FAULT_THRESH=7) used for saturation. A behavioural model tracks the
// expected outputs of both every cycle; directed sequences and a vector
// table add hard-coded expectations.
// -----------------------------------------------------------------------------
module tb_alu_lockstep_checker;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, mode, clr;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   sel0, sel1;

  logic         d1_ov, d1_c0, d1_c1, d1_cd, d1_mis, d1_fault, d1_irq;
  logic [W-1:0] d1_o0, d1_o1, d1_diff;
  logic [7:0]   d1_cnt;
  logic [1:0]   d1_st;

  logic         d2_ov, d2_c0, d2_c1, d2_cd, d2_mis, d2_fault, d2_irq;
  logic [W-1:0] d2_o0, d2_o1, d2_diff;
  logic [2:0]   d2_cnt;
  logic [1:0]   d2_st;

  always #5 clk = ~clk;

  alu_lockstep_checker #(.WIDTH(4), .CNT_W(8), .FAULT_THRESH(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .in_valid_i(in_valid), .mode_i(mode),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .sel0_i(sel0), .sel1_i(sel1),
    .clr_i(clr), .out_valid_o(d1_ov), .alu_out0_o(d1_o0), .alu_out1_o(d1_o1),
    .carry0_o(d1_c0), .carry1_o(d1_c1), .diff_o(d1_diff), .carry_diff_o(d1_cd),
    .mismatch_o(d1_mis), .err_cnt_o(d1_cnt), .state_o(d1_st), .fault_o(d1_fault),
    .irq_o(d1_irq));

  alu_lockstep_checker #(.WIDTH(4), .CNT_W(3), .FAULT_THRESH(7)) dut_sat (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .in_valid_i(in_valid), .mode_i(mode),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1), .sel0_i(sel0), .sel1_i(sel1),
    .clr_i(clr), .out_valid_o(d2_ov), .alu_out0_o(d2_o0), .alu_out1_o(d2_o1),
    .carry0_o(d2_c0), .carry1_o(d2_c1), .diff_o(d2_diff), .carry_diff_o(d2_cd),
    .mismatch_o(d2_mis), .err_cnt_o(d2_cnt), .state_o(d2_st), .fault_o(d2_fault),
    .irq_o(d2_irq));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    bit mode;
    int a0, b0, a1, b1, sel0, sel1;
  } op_t;

  op_t m_s1;
  bit  m_valid;
  int  m_out0, m_c0, m_out1, m_c1;
  int  m_cnt[2];
  bit  m_fault[2];
  bit  m_irq[2];
  int  m_max[2] = '{255, 7};
  int  m_thr[2] = '{4, 7};

  task automatic model_alu(input int a, input int b, input int sel,
                           output int res, output int carry);
    int s;
    carry = 0;
    case (sel)
      0: begin s = a + b; res = s % MOD; carry = s / MOD; end
      1: begin res = (a - b + MOD) % MOD; carry = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (MOD - 1) - a;
      6: begin res = (a * 2) % MOD; carry = (a >= MOD / 2) ? 1 : 0; end
      default: res = b;
    endcase
  endtask

  function automatic int m_state(input int k);
    if (m_fault[k]) return 2;
    return (m_cnt[k] > 0) ? 1 : 0;
  endfunction

  // Advance the model across the upcoming edge using the inputs now driven.
  task automatic model_edge();
    bit mis, nf;
    int nc;
    if (!rst_n) begin
      m_s1 = '{default: 0};
      m_valid = 0;
      m_out0 = 0; m_c0 = 0; m_out1 = 0; m_c1 = 0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_fault[k] = 0; m_irq[k] = 0;
      end
      return;
    end
    mis = m_valid && ((m_out0 != m_out1) || (m_c0 != m_c1));
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_cnt[k] = 0; m_fault[k] = 0; m_irq[k] = 0;
      end else begin
        nc = mis ? ((m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_max[k]) : m_cnt[k];
        nf = m_fault[k] || (nc >= m_thr[k]);
        m_irq[k]   = nf && !m_fault[k];
        m_fault[k] = nf;
        m_cnt[k]   = nc;
      end
    end
    m_valid = m_s1.v;
    if (m_s1.v) begin
      model_alu(m_s1.a0, m_s1.b0, m_s1.sel0, m_out0, m_c0);
      if (m_s1.mode) model_alu(m_s1.a0, m_s1.b0, m_s1.sel0, m_out1, m_c1);
      else           model_alu(m_s1.a1, m_s1.b1, m_s1.sel1, m_out1, m_c1);
    end
    m_s1.v = in_valid;
    if (in_valid) begin
      m_s1.mode = mode;
      m_s1.a0 = int'(a0); m_s1.b0 = int'(b0);
      m_s1.a1 = int'(a1); m_s1.b1 = int'(b1);
      m_s1.sel0 = int'(sel0); m_s1.sel1 = int'(sel1);
    end
  endtask

  task automatic compare_all();
    int  ediff;
    bit  ecd, emis;
    ediff = m_out0 ^ m_out1;
    ecd   = (m_c0 != m_c1);
    emis  = m_valid && ((ediff != 0) || ecd);
    check("out_valid", d1_ov, m_valid);
    check("results", {d1_c0, d1_o0, d1_c1, d1_o1},
          {m_c0[0], m_out0[W-1:0], m_c1[0], m_out1[W-1:0]});
    check("diff", {d1_diff, d1_cd, d1_mis}, {ediff[W-1:0], ecd, emis});
    check("err_cnt", d1_cnt, m_cnt[0]);
    check("state", d1_st, m_state(0));
    check("fault", d1_fault, m_fault[0]);
    check("irq", d1_irq, m_irq[0]);
    check("sat_results", {d2_ov, d2_o0, d2_o1, d2_mis}, {d1_ov, d1_o0, d1_o1, d1_mis} === {m_valid, m_out0[W-1:0], m_out1[W-1:0], emis} ? {m_valid, m_out0[W-1:0], m_out1[W-1:0], emis} : {m_valid, m_out0[W-1:0], m_out1[W-1:0], emis});
    check("sat_err_cnt", d2_cnt, m_cnt[1]);
    check("sat_state", d2_st, m_state(1));
    check("sat_fault", d2_fault, m_fault[1]);
    check("sat_irq", d2_irq, m_irq[1]);
  endtask

  // One clock: model steps, edge occurs, outputs sampled 1 time unit later.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    in_valid = 0; clr = 0; mode = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sel0 = '0; sel1 = '0;
  endtask

  // Channel 0: 5-3 = 2, channel 1: 5^3 = 6, so results always differ.
  task automatic drive_mismatch_op();
    in_valid = 1; mode = 0;
    a0 = 4'd5; b0 = 4'd3; sel0 = 3'b001;
    a1 = 4'd5; b1 = 4'd3; sel1 = 3'b100;
  endtask

  task automatic do_clear();
    clr = 1;
    cycle();
    clr = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         mode;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   sel0, sel1;
    logic [W-1:0] e0, e1;
    logic         ec0, ec1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int irq_seen;

    vecs[0] = '{1'b0, 4'h9, 4'h8, 4'h2, 4'h7, 3'b000, 3'b001, 4'h1, 4'hB, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 4'hC, 4'hA, 4'hC, 4'hA, 3'b010, 3'b011, 4'h8, 4'hE, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'h6, 4'h3, 4'h9, 4'h5, 3'b101, 3'b110, 4'h9, 4'h2, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 4'h3, 4'hD, 4'h7, 4'h7, 3'b111, 3'b001, 4'hD, 4'h0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'hA, 4'h5, 4'h1, 4'h1, 3'b100, 3'b000, 4'hF, 4'hF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'h8, 4'h0, 4'h3, 4'h2, 3'b110, 3'b010, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h1, 3'b000, 3'b001, 4'hE, 4'hF, 1'b1, 1'b1};

    // 1: reset with random inputs
    rst_n = 0;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom); mode = 1'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      sel0 = 3'($urandom); sel1 = 3'($urandom);
      cycle();
    end
    check("reset_outputs", {d1_ov, d1_o0, d1_o1, d1_c0, d1_c1, d1_diff, d1_cd, d1_mis, d1_irq}, 0);
    check("reset_cnt_state", {d1_cnt, d1_st, d1_fault}, 0);
    rst_n = 1;
    idle_inputs();
    cycle();

    // 2: lockstep 0xF + 0x1
    mode = 1; in_valid = 1; a0 = 4'hF; b0 = 4'h1; sel0 = 3'b000;
    a1 = 4'($urandom); b1 = 4'($urandom); sel1 = 3'($urandom);
    cycle();
    idle_inputs();
    cycle();
    check("lockstep_results", {d1_ov, d1_o0, d1_c0, d1_o1, d1_c1}, {1'b1, 4'h0, 1'b1, 4'h0, 1'b1});
    check("lockstep_mismatch", d1_mis, 0);

    // 3: independent sub vs xor
    drive_mismatch_op();
    cycle();
    idle_inputs();
    cycle();
    check("indep_results", {d1_o0, d1_o1, d1_diff}, {4'h2, 4'h6, 4'h4});
    check("indep_mismatch", d1_mis, 1);
    cycle();
    check("indep_cnt_state", {d1_cnt, d1_st}, {8'd1, 2'b01});

    // 4: threshold and single irq
    do_clear();
    drive_mismatch_op();
    irq_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) idle_inputs();
      cycle();
      if (d1_irq) begin
        irq_seen++;
        check("thresh_cnt_at_irq", {d1_cnt, d1_st, d1_fault}, {8'd4, 2'b10, 1'b1});
      end
    end
    check("thresh_irq_pulses", irq_seen, 1);
    check("thresh_final", {d1_cnt, d1_st, d1_fault}, {8'd5, 2'b10, 1'b1});

    // 5: saturation on the 3-bit counter
    do_clear();
    drive_mismatch_op();
    for (int i = 0; i < 14; i++) begin
      if (i == 10) idle_inputs();
      cycle();
    end
    check("sat_cnt", {d2_cnt, d2_st}, {3'd7, 2'b10});
    check("sat_wide_cnt", d1_cnt, 10);

    // 6: clear coincident with a mismatch
    do_clear();
    drive_mismatch_op();
    cycle();
    idle_inputs();
    cycle();
    check("clr_pre_mismatch", {d1_mis, d1_cnt}, {1'b1, 8'd0});
    clr = 1;
    cycle();
    clr = 0;
    check("clr_wins", {d1_cnt, d1_st, d1_irq, d1_fault}, 0);

    // Vector table, back-to-back with mixed modes in flight
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        in_valid = 1; mode = vecs[i].mode;
        a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
        sel0 = vecs[i].sel0; sel1 = vecs[i].sel1;
      end else begin
        idle_inputs();
      end
      cycle();
      if (i >= 1)
        check($sformatf("vec%0d", i - 1), {d1_ov, d1_o0, d1_c0, d1_o1, d1_c1},
              {1'b1, vecs[i-1].e0, vecs[i-1].ec0, vecs[i-1].e1, vecs[i-1].ec1});
    end
    idle_inputs();
    cycle();
    do_clear();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      mode     = ($urandom_range(0, 2) == 0);
      a0 = 4'($urandom); b0 = 4'($urandom);
      sel0 = 3'($urandom); sel1 = 3'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        a1 = a0; b1 = b0; sel1 = sel0;
      end else begin
        a1 = 4'($urandom); b1 = 4'($urandom);
      end
      clr   = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      cycle();
    end
    rst_n = 1;
    idle_inputs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
